// File: rtl/cla_serial_subtractor_pkg.sv
// Shared definitions for the serial carry-lookahead subtractor: group width and FSM encodings.
package cla_serial_subtractor_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_serial_subtractor_cla4.sv
// 4-bit carry-lookahead adder group; every carry is expanded from generate/propagate terms.
module CLA_4bit
    import cla_serial_subtractor_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout
);

    logic [GROUP_W-1:0] g_s;
    logic [GROUP_W-1:0] p_s;
    logic [GROUP_W:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign sum  = p_s ^ c_s[GROUP_W-1:0];
    assign cout = c_s[GROUP_W];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle subtractor: in1 + ~in2 + 1 evaluated one 4-bit CLA group per clock, LSB first,
// with the inter-group carry held in a register.
module cla_serial_subtractor
    import cla_serial_subtractor_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         cout,
    output logic         of
);

    localparam int M     = N / GROUP_W;
    localparam int GRP_W = $clog2(M);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(M - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     diff_q, diff_d;
    logic             in2_msb_q, in2_msb_d;
    logic             carry_q, carry_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic             cout_q, cout_d;
    logic             of_q, of_d;

    logic [GROUP_W-1:0] grp_a_s, grp_b_s, grp_sum_s;
    logic               grp_cout_s;

    assign grp_a_s = a_q[int'(grp_q) * GROUP_W +: GROUP_W];
    assign grp_b_s = b_q[int'(grp_q) * GROUP_W +: GROUP_W];

    CLA_4bit u_cla (
        .a    (grp_a_s),
        .b    (grp_b_s),
        .cin  (carry_q),
        .sum  (grp_sum_s),
        .cout (grp_cout_s)
    );

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        in2_msb_d = in2_msb_q;
        carry_d   = carry_q;
        grp_d     = grp_q;
        cout_d    = cout_q;
        of_d      = of_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = in1;
                    b_d       = ~in2;
                    in2_msb_d = in2[N-1];
                    carry_d   = 1'b1;
                    grp_d     = '0;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                diff_d[int'(grp_q) * GROUP_W +: GROUP_W] = grp_sum_s;
                carry_d = grp_cout_s;
                if (grp_q == LAST_GRP) begin
                    cout_d  = grp_cout_s;
                    // Overflow only when operand signs differ and the result sign departs from in1.
                    of_d    = (a_q[N-1] != in2_msb_q) && (grp_sum_s[GROUP_W-1] != a_q[N-1]);
                    grp_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    grp_d   = grp_q + GRP_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset discards any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            in2_msb_q <= 1'b0;
            carry_q   <= 1'b0;
            grp_q     <= '0;
            cout_q    <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            diff_q    <= diff_d;
            in2_msb_q <= in2_msb_d;
            carry_q   <= carry_d;
            grp_q     <= grp_d;
            cout_q    <= cout_d;
            of_q      <= of_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign cout      = cout_q;
    assign of        = of_q;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed checks of the serial subtractor at N=32 and N=8, plus a short random sweep at N=8.
module tb_cla_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v32_in_valid = 1'b0, v32_out_ready = 1'b0;
    logic [31:0] v32_in1 = 32'd0, v32_in2 = 32'd0;
    logic        v32_in_ready, v32_out_valid, v32_cout, v32_of;
    logic [31:0] v32_diff;

    logic        v8_in_valid = 1'b0, v8_out_ready = 1'b0;
    logic [7:0]  v8_in1 = 8'd0, v8_in2 = 8'd0;
    logic        v8_in_ready, v8_out_valid, v8_cout, v8_of;
    logic [7:0]  v8_diff;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_serial_subtractor #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
        .in1(v32_in1), .in2(v32_in2), .out_valid(v32_out_valid), .out_ready(v32_out_ready),
        .diff(v32_diff), .cout(v32_cout), .of(v32_of)
    );

    cla_serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .in1(v8_in1), .in2(v8_in2), .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .diff(v8_diff), .cout(v8_cout), .of(v8_of)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Accept one operand pair, time the result, optionally stall, then complete the handshake.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_c, input logic exp_of,
                        input int stall);
        int cnt;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(v32_in_ready), 64'd1);
        v32_in1 = a; v32_in2 = b; v32_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32_in_valid = 1'b0;
        cnt = 0;
        while (!v32_out_valid && cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check({tag, ".latency"}, 64'(cnt), 64'd8);
        check({tag, ".diff"}, 64'(v32_diff), 64'(exp_d));
        check({tag, ".cout"}, 64'(v32_cout), 64'(exp_c));
        check({tag, ".of"}, 64'(v32_of), 64'(exp_of));
        for (int i = 0; i < stall; i++) begin
            v32_in_valid = (i == 2);
            v32_in1 = 32'd9; v32_in2 = 32'd1;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(v32_out_valid), 64'd1);
            check({tag, ".hold_diff"}, 64'(v32_diff), 64'(exp_d));
            check({tag, ".hold_flags"}, 64'({v32_cout, v32_of}), 64'({exp_c, exp_of}));
            check({tag, ".hold_in_ready"}, 64'(v32_in_ready), 64'd0);
        end
        // in_valid stays high across the completing edge: must not be taken the same cycle.
        v32_in_valid = (stall > 0);
        v32_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32_out_ready = 1'b0;
        v32_in_valid = 1'b0;
        check({tag, ".release"}, 64'({v32_out_valid, v32_in_ready}), 64'b01);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".no_bypass"}, 64'(v32_in_ready), 64'd1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
        int cnt;
        logic [7:0] exp_d;
        logic exp_c, exp_of;
        exp_d  = a - b;
        exp_c  = (a >= b);
        exp_of = (a[7] != b[7]) && (exp_d[7] != a[7]);
        @(negedge clk);
        v8_in1 = a; v8_in2 = b; v8_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v8_in_valid = 1'b0;
        cnt = 0;
        while (!v8_out_valid && cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check({tag, ".latency"}, 64'(cnt), 64'd2);
        check({tag, ".result"}, 64'({v8_diff, v8_cout, v8_of}), 64'({exp_d, exp_c, exp_of}));
        v8_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v8_out_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("reset32", 64'({v32_in_ready, v32_out_valid, v32_diff, v32_cout, v32_of}),
              64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        op32("basic",     32'd5,          32'd3,          32'h0000_0002, 1'b1, 1'b0, 0);
        op32("borrow",    32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        op32("ovf_neg",   32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        op32("ovf_pos",   32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1'b1, 0);
        op32("sub_zero",  32'h1234_5678,  32'd0,          32'h1234_5678, 1'b1, 1'b0, 0);
        op32("backpress", 32'h0001_0000,  32'd1,          32'h0000_FFFF, 1'b1, 1'b0, 5);
        op32("after_bp",  32'd100,        32'd58,         32'h0000_002A, 1'b1, 1'b0, 0);

        // Abort an operation with grp=3: three BUSY edges after the accept edge.
        @(negedge clk);
        v32_in1 = 32'hFFFF_FFFF; v32_in2 = 32'd0; v32_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_midop", 64'({v32_in_ready, v32_out_valid, v32_diff, v32_cout, v32_of}),
              64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        op32("after_rst", 32'd10, 32'd10, 32'd0, 1'b1, 1'b0, 0);

        op8("n8_basic", 8'd5, 8'd3);
        op8("n8_ovf",   8'h80, 8'h01);
        op8("n8_ovf2",  8'h7F, 8'hFF);
        op8("n8_eq",    8'd10, 8'd10);
        for (int i = 0; i < 300; i++) begin
            op8("n8_rand", 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
